// File: rtl/pid_controller_core_pkg.sv
// Shared widths, latencies and parameter bundle
// for the single-channel PID servo core.
package pid_controller_core_pkg;

  localparam int W_IN     = 18;
  localparam int W_PID    = 48;
  localparam int W_OUT    = 16;
  localparam int W_PAR    = 16;
  localparam int W_RS     = 5;
  localparam int W_S      = 66;
  localparam int PID_LAT  = 4;
  localparam int OPP_LAT  = 4;
  localparam int BUSY_WIN = PID_LAT + OPP_LAT;

  typedef struct packed {
    logic signed [W_PAR-1:0] setpoint;
    logic signed [W_PAR-1:0] p;
    logic signed [W_PAR-1:0] i;
    logic signed [W_PAR-1:0] d;
    logic signed [W_PAR-1:0] mult;
    logic        [W_RS-1:0]  rs;
    logic signed [W_PID-1:0] init;
    logic signed [W_PID-1:0] out_min;
    logic signed [W_PID-1:0] out_max;
  } par_t;

endpackage

// File: rtl/pid_controller_core_opp.sv
// Output post-processing: gain, round-to-zero shift,
// accumulate onto previous DAC code, clamp.
module opp_stage
  import pid_controller_core_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    n_rst_in,
  input  logic                    pid_v,
  input  logic signed [W_PID-1:0] pid,
  input  logic signed [W_PAR-1:0] mult,
  input  logic        [W_RS-1:0]  rs,
  input  logic signed [W_PID-1:0] init,
  input  logic signed [W_PID-1:0] out_min,
  input  logic signed [W_PID-1:0] out_max,
  input  logic                    lock,
  output logic        [W_OUT-1:0] dac,
  output logic                    dac_v
);

  logic signed [W_S-1:0] s1, s2, c3;
  logic signed [W_S-1:0] bias, sat_hi, sat;
  logic                  v1, v2, v3;
  logic                  unused_hi;

  assign bias = (W_S'(1) <<< rs) - W_S'(1);

  // upper limit first so the lower limit wins on overlap
  always_comb begin
    sat_hi = c3;
    sat    = '0;
    if (c3 > W_S'(out_max))
      sat_hi = W_S'(out_max);
    sat = sat_hi;
    if (sat_hi < W_S'(out_min))
      sat = W_S'(out_min);
  end

  assign unused_hi = ^sat[W_S-1:W_OUT];

  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      s1    <= '0;
      s2    <= '0;
      c3    <= '0;
      dac   <= '0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      dac_v <= 1'b0;
    end else begin
      v1    <= pid_v;
      v2    <= v1;
      v3    <= v2;
      dac_v <= v3;
      if (pid_v)
        s1 <= W_S'(pid) * W_S'(mult);
      if (v1)
        s2 <= (s1 + (s1[W_S-1] ? bias : W_S'(0)))
              >>> rs;
      if (v2)
        c3 <= lock
          ? {{(W_S-W_OUT){1'b0}}, dac} + s2
          : W_S'(init);
      if (v3)
        dac <= sat[W_OUT-1:0];
    end
  end

endmodule

// File: rtl/pid_controller_core_pid.sv
// PID front half: error, integral/derivative,
// coefficient products and sum.
module pid_stage
  import pid_controller_core_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    n_rst_in,
  input  logic                    valid,
  input  logic signed [W_IN-1:0]  x,
  input  logic signed [W_PAR-1:0] sp,
  input  logic signed [W_PAR-1:0] p,
  input  logic signed [W_PAR-1:0] i,
  input  logic signed [W_PAR-1:0] d,
  input  logic                    lock,
  output logic signed [W_PID-1:0] pid,
  output logic                    pid_v
);

  logic signed [W_PID-1:0] e1, e2;
  logic signed [W_PID-1:0] integ, eprev, deriv;
  logic signed [W_PID-1:0] pp, pi, pd;
  logic                    v1, v2, v3;

  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      e1    <= '0;
      e2    <= '0;
      integ <= '0;
      eprev <= '0;
      deriv <= '0;
      pp    <= '0;
      pi    <= '0;
      pd    <= '0;
      pid   <= '0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      pid_v <= 1'b0;
    end else begin
      v1    <= valid;
      v2    <= v1;
      v3    <= v2;
      pid_v <= v3;
      if (valid)
        e1 <= W_PID'(sp) - W_PID'(x);
      if (v1) begin
        e2    <= e1;
        deriv <= e1 - eprev;
        // unlocked: loop memory is flushed every sample
        integ <= lock ? integ + e1 : '0;
        eprev <= lock ? e1 : '0;
      end
      if (v2) begin
        pp <= W_PID'(p) * e2;
        pi <= W_PID'(i) * integ;
        pd <= W_PID'(d) * deriv;
      end
      if (v3)
        pid <= pp + pi + pd;
    end
  end

endmodule

// File: rtl/pid_controller_core.sv
// PID servo channel top: parameter shadows,
// sample admission window, PID and output stages.
module pid_controller_core
  import pid_controller_core_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    n_rst_in,
  input  logic signed [W_IN-1:0]  data_in,
  input  logic                    data_valid_in,
  input  logic signed [15:0]      setpoint_in,
  input  logic signed [15:0]      p_coef_in,
  input  logic signed [15:0]      i_coef_in,
  input  logic signed [15:0]      d_coef_in,
  input  logic signed [15:0]      multiplier_in,
  input  logic        [4:0]       right_shift_in,
  input  logic signed [47:0]      output_init_in,
  input  logic signed [47:0]      output_min_in,
  input  logic signed [47:0]      output_max_in,
  input  logic                    lock_en_in,
  input  logic                    update_en_in,
  input  logic                    update_in,
  output logic signed [W_PID-1:0] pid_data_out,
  output logic                    pid_data_valid_out,
  output logic        [W_OUT-1:0] dac_data_out,
  output logic                    dac_data_valid_out
);

  par_t       par_d, par_q, act_q;
  logic [3:0] busy;
  logic       accept;

  always_comb begin
    par_d          = '0;
    par_d.setpoint = setpoint_in;
    par_d.p        = p_coef_in;
    par_d.i        = i_coef_in;
    par_d.d        = d_coef_in;
    par_d.mult     = multiplier_in;
    par_d.rs       = right_shift_in;
    par_d.init     = output_init_in;
    par_d.out_min  = output_min_in;
    par_d.out_max  = output_max_in;
  end

  assign accept = data_valid_in && (busy == 4'd0);

  // act_q freezes params for the sample in flight
  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      par_q <= '0;
      act_q <= '0;
      busy  <= '0;
    end else begin
      if (update_in && update_en_in)
        par_q <= par_d;
      if (accept) begin
        act_q <= par_q;
        busy  <= 4'(BUSY_WIN - 1);
      end else if (busy != 4'd0) begin
        busy  <= busy - 4'd1;
      end
    end
  end

  pid_stage u_pid (
    .clk_in   (clk_in),
    .n_rst_in (n_rst_in),
    .valid    (accept),
    .x        (data_in),
    .sp       (par_q.setpoint),
    .p        (act_q.p),
    .i        (act_q.i),
    .d        (act_q.d),
    .lock     (lock_en_in),
    .pid      (pid_data_out),
    .pid_v    (pid_data_valid_out)
  );

  opp_stage u_opp (
    .clk_in   (clk_in),
    .n_rst_in (n_rst_in),
    .pid_v    (pid_data_valid_out),
    .pid      (pid_data_out),
    .mult     (act_q.mult),
    .rs       (act_q.rs),
    .init     (act_q.init),
    .out_min  (act_q.out_min),
    .out_max  (act_q.out_max),
    .lock     (lock_en_in),
    .dac      (dac_data_out),
    .dac_v    (dac_data_valid_out)
  );

endmodule

// File: tb/tb_pid_controller_core.sv
// Scoreboard bench for pid_controller_core with
// an arithmetic reference model of the servo law.
module tb_pid_controller_core;

  logic               clk_in = 1'b0;
  logic               n_rst_in = 1'b0;
  logic signed [17:0] data_in = '0;
  logic               data_valid_in = 1'b0;
  logic signed [15:0] setpoint_in = '0;
  logic signed [15:0] p_coef_in = '0;
  logic signed [15:0] i_coef_in = '0;
  logic signed [15:0] d_coef_in = '0;
  logic signed [15:0] multiplier_in = '0;
  logic        [4:0]  right_shift_in = '0;
  logic signed [47:0] output_init_in = '0;
  logic signed [47:0] output_min_in = '0;
  logic signed [47:0] output_max_in = '0;
  logic               lock_en_in = 1'b0;
  logic               update_en_in = 1'b0;
  logic               update_in = 1'b0;
  logic signed [47:0] pid_data_out;
  logic               pid_data_valid_out;
  logic        [15:0] dac_data_out;
  logic               dac_data_valid_out;

  pid_controller_core dut (
    .clk_in             (clk_in),
    .n_rst_in           (n_rst_in),
    .data_in            (data_in),
    .data_valid_in      (data_valid_in),
    .setpoint_in        (setpoint_in),
    .p_coef_in          (p_coef_in),
    .i_coef_in          (i_coef_in),
    .d_coef_in          (d_coef_in),
    .multiplier_in      (multiplier_in),
    .right_shift_in     (right_shift_in),
    .output_init_in     (output_init_in),
    .output_min_in      (output_min_in),
    .output_max_in      (output_max_in),
    .lock_en_in         (lock_en_in),
    .update_en_in       (update_en_in),
    .update_in          (update_in),
    .pid_data_out       (pid_data_out),
    .pid_data_valid_out (pid_data_valid_out),
    .dac_data_out       (dac_data_out),
    .dac_data_valid_out (dac_data_valid_out)
  );

  always #5 clk_in = ~clk_in;

  int     n_vec = 0;
  int     n_err = 0;
  int     n_pid = 0;
  int     n_dac = 0;
  longint last_pid = 0;
  longint last_dac = 0;
  longint q_pid[$];
  longint q_dac[$];

  longint m_sp, m_p, m_i, m_d, m_mult;
  longint m_init, m_lo, m_hi;
  int     m_rs;
  longint m_integ, m_eprev, m_prev;

  task automatic chk(input string nm,
                     input longint got,
                     input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d",
               nm, got, exp);
    end
  endtask

  function automatic longint w48(input longint v);
    longint t;
    t = v;
    return {{16{t[47]}}, t[47:0]};
  endfunction

  task automatic model_reset();
    m_sp = 0; m_p = 0; m_i = 0; m_d = 0;
    m_mult = 0; m_rs = 0;
    m_init = 0; m_lo = 0; m_hi = 0;
    m_integ = 0; m_eprev = 0; m_prev = 0;
  endtask

  task automatic load_shadow();
    m_sp   = longint'(setpoint_in);
    m_p    = longint'(p_coef_in);
    m_i    = longint'(i_coef_in);
    m_d    = longint'(d_coef_in);
    m_mult = longint'(multiplier_in);
    m_rs   = int'(right_shift_in);
    m_init = longint'(output_init_in);
    m_lo   = longint'(output_min_in);
    m_hi   = longint'(output_max_in);
  endtask

  // servo law straight from the arithmetic definition
  task automatic model(input longint x, input bit l);
    longint e, dv, u, s, c;
    e  = m_sp - x;
    dv = e - m_eprev;
    if (l) begin
      m_integ = w48(m_integ + e);
      m_eprev = e;
    end else begin
      m_integ = 0;
      m_eprev = 0;
    end
    u = w48(m_p * e + m_i * m_integ + m_d * dv);
    s = u * m_mult;
    s = s / (longint'(1) << m_rs);
    c = l ? m_prev + s : m_init;
    if (c > m_hi) c = m_hi;
    if (c < m_lo) c = m_lo;
    m_prev = c & 64'hFFFF;
    q_pid.push_back(u);
    q_dac.push_back(m_prev);
  endtask

  always @(negedge clk_in) begin
    if (n_rst_in && pid_data_valid_out) begin
      n_pid++;
      last_pid = longint'(pid_data_out);
      if (q_pid.size() == 0)
        chk("pid_unexpected", last_pid, -1);
      else
        chk("pid", last_pid, q_pid.pop_front());
    end
    if (n_rst_in && dac_data_valid_out) begin
      n_dac++;
      last_dac = longint'(dac_data_out);
      if (q_dac.size() == 0)
        chk("dac_unexpected", last_dac, -1);
      else
        chk("dac", last_dac, q_dac.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
  endtask

  task automatic do_update(input bit en);
    @(posedge clk_in); #1;
    update_in    = 1'b1;
    update_en_in = en;
    @(posedge clk_in); #1;
    update_in    = 1'b0;
    update_en_in = 1'b0;
    if (en) load_shadow();
  endtask

  task automatic issue(input longint x, input bit l,
                       input bit upd, input bit push);
    @(posedge clk_in); #1;
    data_in       = 18'(x);
    lock_en_in    = l;
    data_valid_in = 1'b1;
    update_in     = upd;
    update_en_in  = upd;
    @(posedge clk_in); #1;
    data_valid_in = 1'b0;
    update_in     = 1'b0;
    update_en_in  = 1'b0;
    if (push) model(longint'(data_in), l);
    if (upd) load_shadow();
  endtask

  task automatic do_reset();
    @(posedge clk_in); #1;
    n_rst_in = 1'b0;
    idle(2);
    #1;
    chk("rst_pid", longint'(pid_data_out), 0);
    chk("rst_pidv", longint'(pid_data_valid_out), 0);
    chk("rst_dac", longint'(dac_data_out), 0);
    chk("rst_dacv", longint'(dac_data_valid_out), 0);
    model_reset();
    n_rst_in = 1'b1;
  endtask

  task automatic set_base();
    setpoint_in    = 16'sd0;
    p_coef_in      = 16'sd10;
    i_coef_in      = 16'sd3;
    d_coef_in      = 16'sd2;
    multiplier_in  = 16'sd1;
    right_shift_in = 5'd9;
    output_init_in = 48'sd0;
    output_min_in  = 48'sd1;
    output_max_in  = 48'sd52428;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, d0;
    logic signed [17:0] xr;
    model_reset();
    do_reset();

    set_base();
    do_update(1'b1);
    issue(-100, 1'b1, 1'b0, 1'b1); idle(12);
    chk("t1_pid", last_pid, 1500);
    chk("t1_dac", last_dac, 2);
    issue(-100, 1'b1, 1'b0, 1'b1); idle(12);
    chk("t1b_pid", last_pid, 1600);
    chk("t1b_dac", last_dac, 5);

    do_reset();
    do_update(1'b1);
    issue(1000, 1'b1, 1'b0, 1'b1); idle(12);
    chk("t2_pid", last_pid, -15000);
    chk("t2_dac", last_dac, 1);

    output_init_in = 48'sd13107;
    do_update(1'b1);
    issue(777, 1'b0, 1'b0, 1'b1); idle(12);
    chk("t3_dac", last_dac, 13107);
    issue(-100, 1'b1, 1'b0, 1'b1); idle(12);
    chk("t3b_pid", last_pid, 1500);
    chk("t3b_dac", last_dac, 13109);

    output_init_in = 48'sd60000;
    do_update(1'b1);
    issue(5, 1'b0, 1'b0, 1'b1); idle(12);
    chk("t4_max", last_dac, 52428);
    output_min_in = 48'sd100;
    output_max_in = 48'sd50;
    do_update(1'b1);
    issue(5, 1'b0, 1'b0, 1'b1); idle(12);
    chk("t4_min", last_dac, 100);

    set_base();
    do_update(1'b1);
    c0 = n_pid; d0 = n_dac;
    issue(40, 1'b1, 1'b0, 1'b1);
    idle(1);
    issue(-9000, 1'b1, 1'b0, 1'b0);
    idle(14);
    chk("drop_pid_cnt", n_pid - c0, 1);
    chk("drop_dac_cnt", n_dac - d0, 1);

    issue(-100, 1'b0, 1'b0, 1'b1); idle(12);
    p_coef_in = 16'sd99;
    do_update(1'b0);
    issue(-100, 1'b1, 1'b0, 1'b1); idle(12);
    chk("t6_hold", last_pid, 1500);
    issue(-100, 1'b1, 1'b1, 1'b1); idle(12);
    chk("t6_old", last_pid, 1600);
    issue(-100, 1'b1, 1'b0, 1'b1); idle(12);
    chk("t6_new", last_pid, 10800);

    c0 = n_pid; d0 = n_dac;
    issue(123, 1'b1, 1'b0, 1'b0);
    idle(2);
    do_reset();
    idle(12);
    chk("midrst_pid", n_pid - c0, 0);
    chk("midrst_dac", n_dac - d0, 0);

    for (int k = 0; k < 100; k++) begin
      bit up_now;
      up_now = 1'b0;
      if (k % 10 == 0) begin
        setpoint_in    = 16'($urandom);
        p_coef_in      = 16'($urandom);
        i_coef_in      = 16'($urandom);
        d_coef_in      = 16'($urandom);
        multiplier_in  = 16'($urandom);
        right_shift_in = 5'($urandom);
        output_init_in = 48'($urandom_range(65535));
        if ($urandom_range(1) == 0) begin
          output_min_in = 48'sd0;
          output_max_in = 48'sd65535;
        end else begin
          output_min_in =
            48'(longint'($urandom_range(4000)) - 2000);
          output_max_in =
            48'($urandom_range(70000));
        end
        if (k == 0 || $urandom_range(1) == 0)
          do_update(1'b1);
        else
          up_now = 1'b1;
      end
      xr = 18'($urandom);
      issue(longint'(xr), $urandom_range(9) != 0,
            up_now, 1'b1);
      idle($urandom_range(6, 10));
    end
    idle(12);

    chk("q_pid_left", longint'(q_pid.size()), 0);
    chk("q_dac_left", longint'(q_dac.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pid_controller_core.md
# pid_controller_core

Single-channel PID servo core with output post-processing. It takes one signed ADC sample per conversion and computes the PID control value against a programmable setpoint. The control value is scaled, accumulated onto the previous output, and clamped to produce a 16-bit DAC code. It sits between the oversampling-filter output and the DAC serializer; all parameters arrive from front-panel wire-ins via a latch-on-update strobe.

## Interface
- W_IN, 18: input sample width (signed)
- W_PID, 48: PID output / integral width (signed)
- W_OUT, 16: DAC code width (unsigned)
- clk_in  in  1  system clock; one clock, all logic on rising edge
- n_rst_in  in  1  reset, asynchronous, active-low
- data_in  in  W_IN  signed sample
- data_valid_in  in  1  one-cycle sample strobe
- setpoint_in, p_coef_in, i_coef_in, d_coef_in  in  16 each  signed PID params
- multiplier_in  in  16  signed output gain
- right_shift_in  in  5  output attenuation exponent, 0..31
- output_init_in, output_min_in, output_max_in  in  48 each  signed output init and limits
- lock_en_in  in  1  lock enable, level, used directly (not latched)
- update_en_in  in  1  sensitize this channel to update strobe
- update_in  in  1  one-cycle parameter-latch strobe
- pid_data_out  out  W_PID  signed PID value
- pid_data_valid_out  out  1  one-cycle strobe
- dac_data_out  out  16  DAC code
- dac_data_valid_out  out  1  one-cycle strobe

## Operation
- Parameters are latched into shadow registers when update_in && update_en_in; otherwise held. Reset value of all shadows is 0.
- On each accepted sample x:
  - e = sign-extend(setpoint) − x
  - integral += e
  - deriv = e − e_prev
  - e_prev = e
  - u = p·e + i·integral + d·deriv, in W_PID two's-complement wrap
- Output stage, computed at ≥66-bit signed:
  - s = u·multiplier
  - s = s / 2^right_shift, truncated toward zero (negatives are biased by 2^rs−1 before the arithmetic shift)
  - c = lock_en ? (prev_out + s) : output_init, where prev_out is the zero-extended current dac_data_out
  - result = max(min(c, output_max), output_min); max is applied first, so min wins if min > max
  - dac_data_out = result[15:0]
- While lock_en_in=0, integral and e_prev are cleared each sample. The PID value is still produced.
- Samples arriving while the core is busy (fewer than 8 cycles after the previous accepted sample) are dropped.
- Reset values: all outputs 0, valids 0, integral/e_prev 0, prev_out 0.

## Timing
- Fixed pipeline, no stalls:
  - data_valid_in → error register: +1
  - integral/deriv: +2
  - products: +3
  - pid_data_valid_out: +4 cycles
- From pid_data_valid_out:
  - scale: +1
  - shift: +2
  - accumulate/select: +3
  - clamp, then dac_data_valid_out: +4 cycles (8 cycles after the sample)
- update_in coincident with data_valid_in: the sample uses the old params; the new params take effect from the next sample.
- The busy window is 8 cycles, so accumulation always uses the settled prev_out.
- Reset deassertion mid-pipeline: all in-flight strobes are discarded and no valid strobes are emitted.

## Structure
- Shared package holds W_IN, W_PID, W_OUT, the pipeline latency constants (PID_LAT=4, OPP_LAT=4), and the busy window.
- Split into two sub-modules:
  - pid_stage: error, integral, deriv, MAC
  - opp_stage: scale, shift, accumulate, clamp
- Parameter shadow registers live in the top.

## Test plan
- setpoint 0, p=10, i=3, d=2, mult 1, rs 9, min 1, max 52428, lock on; sample −100 → pid 1500, dac 2; second −100 → pid 1600, dac 5.
- From reset, same params, sample +1000 → pid −15000, scaled −29 (toward zero), dac clamped to 1.
- Lock off, init 13107, any sample → dac 13107 and integral stays 0. Lock on, sample −100 → pid 1500 and dac 13107+2=13109.
- Lock off, init 60000, max 52428 → dac 52428. Then min 100, max 50 → dac 100.
- Second sample 3 cycles after the first → dropped: exactly one pid valid and one dac valid.
- Update strobe with update_en=0 → params unchanged. Strobe with update_en=1 on the same cycle as a sample → the old coefs are used for that sample.
- Random 100 samples → bench model matches pid and dac on every strobe.
